// File: rtl/spin_phase_sampler_pkg.sv
// Shared types and constants for the spin phase sampler.
// Build option: define PHASE_EDGE_COUNT_EN to add the reference rising-edge counter at rd_addr==N.
package spin_phase_sampler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } sampler_state_t;

  // Matches the oscillator matrix's value for unmapped register reads.
  localparam logic [31:0] RDATA_DEFAULT = 32'hAAAA_AAAA;

endpackage

// File: rtl/spin_phase_sampler_if.sv
// Measurement control, oscillator input and readback bus of the spin phase sampler.
interface spin_phase_sampler_if #(
  parameter int N             = 8,
  parameter int COUNTER_WIDTH = 20
);
  localparam int ADDR_W = $clog2(N) + 1;

  logic [N-1:0]             right_col;
  logic                     start;
  logic [COUNTER_WIDTH-1:0] cycles;
  logic                     busy;
  logic                     done;
  logic [ADDR_W-1:0]        rd_addr;
  logic [31:0]              rdata;
  logic [N-1:0]             spin_out;

  modport master (
    output right_col, start, cycles, rd_addr,
    input  busy, done, rdata, spin_out
  );

  modport slave (
    input  right_col, start, cycles, rd_addr,
    output busy, done, rdata, spin_out
  );
endinterface

// File: rtl/spin_phase_sampler_phase_bit_counter.sv
// One spin lane: synchroniser for the raw oscillator bit plus a saturating in-phase counter.
module phase_bit_counter
  import spin_phase_sampler_pkg::*;
#(
  parameter int COUNTER_WIDTH = 20,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     raw_bit,
  input  logic                     sync_ref,
  input  logic                     clr,
  input  logic                     en,
  output logic                     sync_bit,
  output logic [COUNTER_WIDTH-1:0] count
);

  logic [SYNC_STAGES-1:0] sync_q;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      count  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_bit};
      if (clr) begin
        count <= '0;
      end else if (en && (sync_bit == sync_ref) && (count != '1)) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spin_phase_sampler.sv
// Measures per-spin phase agreement with reference spin N-1 over a programmed window.
// Build option: PHASE_EDGE_COUNT_EN adds a reference rising-edge counter read at rd_addr==N.
module spin_phase_sampler
  import spin_phase_sampler_pkg::*;
#(
  parameter int N             = 8,
  parameter int COUNTER_WIDTH = 20,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                 clk,
  input  logic                 axi_rstn,
  spin_phase_sampler_if.slave  bus
);

  localparam int ADDR_W = $clog2(N) + 1;
  localparam logic [ADDR_W-1:0] REF_ADDR = ADDR_W'(N);

  typedef logic [COUNTER_WIDTH-1:0] count_t;

  sampler_state_t state;
  count_t         win_len;
  count_t         remaining;
  count_t         count [N];
  logic [N-1:0]   sync_bits;
  logic [N-1:0]   spin_next;
  logic           cnt_clr;
  logic           cnt_en;
  logic           busy_q;
  logic           done_q;
  logic [31:0]    rdata_q;
  logic [N-1:0]   spin_q;
  logic           unused_sync_bits;

  assign cnt_clr = (state == ST_CLEAR);
  assign cnt_en  = (state == ST_MEASURE);

  // Only the reference lane's synced bit feeds logic; the others exist for probing.
  assign unused_sync_bits = ^sync_bits[N-2:0];

  for (genvar i = 0; i < N; i++) begin : g_lane
    phase_bit_counter #(
      .COUNTER_WIDTH(COUNTER_WIDTH),
      .SYNC_STAGES  (SYNC_STAGES)
    ) u_lane (
      .clk     (clk),
      .rst_n   (axi_rstn),
      .raw_bit (bus.right_col[i]),
      .sync_ref(sync_bits[N-1]),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .sync_bit(sync_bits[i]),
      .count   (count[i])
    );
  end

  // Majority decision done one bit wider so 2*count cannot overflow.
  always_comb begin
    spin_next = '0;
    for (int i = 0; i < N; i++) begin
      spin_next[i] = ({count[i], 1'b0} >= {1'b0, win_len});
    end
  end

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state     <= ST_IDLE;
      win_len   <= '0;
      remaining <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      spin_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            win_len <= bus.cycles;
            busy_q  <= 1'b1;
            state   <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          remaining <= win_len;
          if (win_len == '0) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end else begin
            state <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          remaining <= remaining - 1'b1;
          if (remaining == COUNTER_WIDTH'(1)) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          spin_q <= spin_next;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PHASE_EDGE_COUNT_EN
  logic   ref_prev;
  count_t edge_count;

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      ref_prev   <= 1'b0;
      edge_count <= '0;
    end else begin
      ref_prev <= sync_bits[N-1];
      if (cnt_clr) begin
        edge_count <= '0;
      end else if (cnt_en && !ref_prev && sync_bits[N-1] && (edge_count != '1)) begin
        edge_count <= edge_count + 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      rdata_q <= '0;
    end else if (bus.rd_addr < REF_ADDR) begin
      rdata_q <= 32'(count[bus.rd_addr[ADDR_W-2:0]]);
`ifdef PHASE_EDGE_COUNT_EN
    end else if (bus.rd_addr == REF_ADDR) begin
      rdata_q <= 32'(edge_count);
`endif
    end else begin
      rdata_q <= RDATA_DEFAULT;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rdata    = rdata_q;
  assign bus.spin_out = spin_q;

endmodule

// File: tb/tb_spin_phase_sampler.sv
// Randomised bench for spin_phase_sampler; expected counts come from a sample-history model.
// Honours PHASE_EDGE_COUNT_EN the same way as the design.
module tb_spin_phase_sampler;

  localparam int N          = 8;
  localparam int CW         = 20;
  localparam int CW_NARROW  = 4;
  localparam int S          = 2;
  localparam int ADDR_W     = $clog2(N) + 1;
  localparam int HIST_DEPTH = 16384;

  logic         clk = 1'b0;
  logic         axi_rstn;
  logic [N-1:0] rc;
  int           checks   = 0;
  int           failures = 0;
  logic [N-1:0] hist [HIST_DEPTH];
  int           edge_cnt  = 0;
  int           stim_mode = 0;
  int           phase_cnt = 0;
  logic [N-1:0] const_val = '0;

  spin_phase_sampler_if #(.N(N), .COUNTER_WIDTH(CW))        bus ();
  spin_phase_sampler_if #(.N(N), .COUNTER_WIDTH(CW_NARROW)) bus_n ();

  assign bus.right_col   = rc;
  assign bus_n.right_col = rc;

  spin_phase_sampler #(.N(N), .COUNTER_WIDTH(CW), .SYNC_STAGES(S)) dut (
    .clk(clk), .axi_rstn(axi_rstn), .bus(bus)
  );

  spin_phase_sampler #(.N(N), .COUNTER_WIDTH(CW_NARROW), .SYNC_STAGES(S)) dut_narrow (
    .clk(clk), .axi_rstn(axi_rstn), .bus(bus_n)
  );

  always #5 clk = ~clk;

  // Value of right_col captured by the first synchroniser flop at each rising edge.
  always @(posedge clk) begin
    hist[edge_cnt % HIST_DEPTH] = rc;
    edge_cnt++;
  end

  initial begin
    rc = '0;
    forever begin
      @(negedge clk);
      phase_cnt++;
      case (stim_mode)
        1:       rc = {N{(phase_cnt % 10) < 5}};
        2:       rc = {{4{(phase_cnt % 10) < 5}}, {4{(phase_cnt % 10) >= 5}}};
        3:       rc = const_val;
        4:       rc = rc ^ (N'($urandom) & N'($urandom) & N'($urandom));
        default: rc = N'($urandom);
      endcase
    end
  end

  function automatic logic [N-1:0] h(input int e);
    return hist[e % HIST_DEPTH];
  endfunction

  // A window accepted at edge e0 samples at edges e0+2 .. e0+1+w, each seeing the value captured S edges earlier.
  function automatic int model_count(input int e0, input int w, input int b, input int cw);
    int c   = 0;
    int sat = (1 << cw) - 1;
    logic [N-1:0] v;
    for (int k = 0; k < w; k++) begin
      v = h(e0 + 2 + k - S);
      if (v[b] == v[N-1] && c < sat) c++;
    end
    return c;
  endfunction

  function automatic int model_edges(input int e0, input int w, input int cw);
    int c   = 0;
    int sat = (1 << cw) - 1;
    logic [N-1:0] cur, prev;
    for (int k = 0; k < w; k++) begin
      cur  = h(e0 + 2 + k - S);
      prev = h(e0 + 1 + k - S);
      if (!prev[N-1] && cur[N-1] && c < sat) c++;
    end
    return c;
  endfunction

  function automatic logic [N-1:0] model_spin(input int e0, input int w, input int cw);
    logic [N-1:0] s = '0;
    for (int i = 0; i < N; i++) s[i] = (2 * model_count(e0, w, i, cw) >= w);
    return s;
  endfunction

  function automatic logic [31:0] model_read(input int e0, input int w, input int a, input int cw);
    if (a < N) return 32'(model_count(e0, w, a, cw));
`ifdef PHASE_EDGE_COUNT_EN
    if (a == N) return 32'(model_edges(e0, w, cw));
`endif
    return 32'hAAAA_AAAA;
  endfunction

  task automatic run_window(input int w, input bit interfere, input bit coincide);
    int e0;
    int done_edge = -1;
    bit seen = 1'b0;
    logic [N-1:0] exp_spin;
    logic [31:0]  exp_rd;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.cycles = CW'(w);
    @(posedge clk); #1;
    e0 = edge_cnt - 1;
    for (int it = 0; it < w + 20 && !seen; it++) begin
      @(negedge clk);
      bus.start = interfere && (it == w / 2);
      if (bus.start) bus.cycles = CW'($urandom_range(1, 50));
      @(posedge clk); #1;
      if (bus.done) begin
        seen      = 1'b1;
        done_edge = edge_cnt - 1;
      end
    end
    checks++;
    if (!seen || done_edge != e0 + 1 + w) begin
      failures++;
      $display("[TB] FAIL done_timing w=%0d: got edge %0d expected edge %0d", w, done_edge, e0 + 1 + w);
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL busy_at_done: got %b expected 1", bus.busy);
    end
    @(negedge clk);
    bus.start  = coincide;
    bus.cycles = CW'(5);
    @(posedge clk); #1;
    exp_spin = model_spin(e0, w, CW);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL after_done: got done=%b busy=%b expected done=0 busy=0", bus.done, bus.busy);
    end
    checks++;
    if (bus.spin_out !== exp_spin) begin
      failures++;
      $display("[TB] FAIL spin_out w=%0d: got %h expected %h", w, bus.spin_out, exp_spin);
    end
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL start_at_done_ignored: got busy=%b expected 0", bus.busy);
    end
    for (int a = 0; a < 2 * N; a++) begin
      @(negedge clk);
      bus.rd_addr = ADDR_W'(a);
      @(posedge clk); #1;
      exp_rd = model_read(e0, w, a, CW);
      checks++;
      if (bus.rdata !== exp_rd) begin
        failures++;
        $display("[TB] FAIL readback addr=%0d w=%0d: got %h expected %h", a, w, bus.rdata, exp_rd);
      end
    end
  endtask

  task automatic test_reset;
    axi_rstn = 1'b0;
    stim_mode = 0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got busy=%b done=%b expected 0 0", bus.busy, bus.done);
    end
    checks++;
    if (bus.rdata !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_rdata: got %h expected 0", bus.rdata);
    end
    checks++;
    if (bus.spin_out !== '0) begin
      failures++;
      $display("[TB] FAIL reset_spin_out: got %h expected 0", bus.spin_out);
    end
    @(negedge clk);
    axi_rstn = 1'b1;
    bus.rd_addr = '0;
    repeat (S + 3) @(posedge clk);
    #1;
    checks++;
    if (bus.rdata !== 32'h0) begin
      failures++;
      $display("[TB] FAIL post_reset_read0: got %h expected 0", bus.rdata);
    end
  endtask

  task automatic test_in_phase;
    stim_mode = 1;
    run_window(100, 1'b0, 1'b0);
    checks++;
    if (bus.spin_out !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL in_phase_spin: got %h expected ff", bus.spin_out);
    end
  endtask

  task automatic test_anti_phase;
    stim_mode = 2;
    run_window(100, 1'b0, 1'b0);
    checks++;
    if (bus.spin_out !== 8'hF0) begin
      failures++;
      $display("[TB] FAIL anti_phase_spin: got %h expected f0", bus.spin_out);
    end
  endtask

  task automatic test_empty_window;
    stim_mode = 0;
    run_window(0, 1'b0, 1'b0);
    checks++;
    if (bus.spin_out !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL empty_window_spin: got %h expected ff", bus.spin_out);
    end
  endtask

  task automatic test_back_to_back;
    stim_mode = 4;
    run_window(60, 1'b1, 1'b1);
    run_window(1, 1'b1, 1'b1);
  endtask

  task automatic test_random_windows;
    for (int r = 0; r < 6; r++) begin
      stim_mode = $urandom_range(0, 4);
      const_val = N'($urandom);
      run_window($urandom_range(1, 200), 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_narrow_counter;
    int e0;
    int done_edge;
    bit seen;
    logic [N-1:0] exp_spin;
    logic [31:0]  exp_rd;
    for (int r = 0; r < 2; r++) begin
      stim_mode = (r == 0) ? 3 : 0;
      const_val = N'($urandom);
      @(negedge clk);
      bus_n.start  = 1'b1;
      bus_n.cycles = 4'd15;
      @(posedge clk); #1;
      e0 = edge_cnt - 1;
      @(negedge clk);
      bus_n.start = 1'b0;
      seen = 1'b0;
      done_edge = -1;
      for (int it = 0; it < 40 && !seen; it++) begin
        @(posedge clk); #1;
        if (bus_n.done) begin
          seen      = 1'b1;
          done_edge = edge_cnt - 1;
        end
      end
      checks++;
      if (!seen || done_edge != e0 + 16) begin
        failures++;
        $display("[TB] FAIL narrow_done_timing: got edge %0d expected edge %0d", done_edge, e0 + 16);
      end
      @(posedge clk); #1;
      exp_spin = model_spin(e0, 15, CW_NARROW);
      checks++;
      if (bus_n.spin_out !== exp_spin) begin
        failures++;
        $display("[TB] FAIL narrow_spin_out: got %h expected %h", bus_n.spin_out, exp_spin);
      end
      for (int a = 0; a < N; a++) begin
        @(negedge clk);
        bus_n.rd_addr = ADDR_W'(a);
        @(posedge clk); #1;
        exp_rd = model_read(e0, 15, a, CW_NARROW);
        checks++;
        if (bus_n.rdata !== exp_rd) begin
          failures++;
          $display("[TB] FAIL narrow_count addr=%0d: got %h expected %h", a, bus_n.rdata, exp_rd);
        end
      end
    end
  endtask

  task automatic test_reset_mid_window;
    bit saw_done = 1'b0;
    stim_mode = 0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.cycles = CW'(100);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (41) @(posedge clk);
    @(negedge clk);
    axi_rstn = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.spin_out !== '0) begin
      failures++;
      $display("[TB] FAIL mid_reset_outputs: got busy=%b done=%b spin=%h expected 0 0 0",
               bus.busy, bus.done, bus.spin_out);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    axi_rstn = 1'b1;
    for (int k = 0; k < 110; k++) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset_no_done: got done pulse=%b expected 0", saw_done);
    end
    for (int a = 0; a < N; a++) begin
      @(negedge clk);
      bus.rd_addr = ADDR_W'(a);
      @(posedge clk); #1;
      checks++;
      if (bus.rdata !== 32'h0) begin
        failures++;
        $display("[TB] FAIL mid_reset_count addr=%0d: got %h expected 0", a, bus.rdata);
      end
    end
    run_window(80, 1'b0, 1'b0);
  endtask

  task automatic test_readback_oob;
    logic [31:0] exp_ref;
    @(negedge clk);
    bus.rd_addr = ADDR_W'(9);
    @(posedge clk); #1;
    checks++;
    if (bus.rdata !== 32'hAAAA_AAAA) begin
      failures++;
      $display("[TB] FAIL oob_addr9: got %h expected aaaaaaaa", bus.rdata);
    end
    stim_mode = 1;
    run_window(100, 1'b0, 1'b0);
    @(negedge clk);
    bus.rd_addr = ADDR_W'(N);
    @(posedge clk); #1;
`ifdef PHASE_EDGE_COUNT_EN
    exp_ref = 32'd10;
    checks++;
    if (bus.rdata < exp_ref - 1 || bus.rdata > exp_ref + 1) begin
      failures++;
      $display("[TB] FAIL edge_count_ref: got %0d expected 10+-1", bus.rdata);
    end
`else
    exp_ref = 32'hAAAA_AAAA;
    checks++;
    if (bus.rdata !== exp_ref) begin
      failures++;
      $display("[TB] FAIL addr_n_default: got %h expected %h", bus.rdata, exp_ref);
    end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    axi_rstn      = 1'b0;
    bus.start     = 1'b0;
    bus.cycles    = '0;
    bus.rd_addr   = '0;
    bus_n.start   = 1'b0;
    bus_n.cycles  = '0;
    bus_n.rd_addr = '0;
    test_reset();
    test_in_phase();
    test_anti_phase();
    test_empty_window();
    test_back_to_back();
    test_random_windows();
    test_narrow_counter();
    test_reset_mid_window();
    test_readback_oob();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spin_phase_sampler.md
Name: spin_phase_sampler

Overview:
- Downstream consumer of the coupled-oscillator matrix's `right_col` bus.
- Synchronises each free-running spin oscillator into the `clk` domain.
- Over a programmed window, counts the cycles each spin is in phase with reference spin N-1.
- Exposes the per-spin counts and decoded spin values for register readback by the AXI control logic.

Parameters:
- N, 8: number of spins; width of `right_col`; power of two.
- COUNTER_WIDTH, 20: width of the window length and per-spin counters; must be ≤32.
- SYNC_STAGES, 2: flops in each per-bit synchroniser; must be ≥2.

Ports:
- clk  input  1  system/AXI clock.
- axi_rstn  input  1  asynchronous active-low reset.
- right_col  input  N  raw oscillator outputs, asynchronous to clk; bit N-1 is the reference.
- start  input  1  single-cycle request to begin a measurement.
- cycles  input  COUNTER_WIDTH  window length in clk cycles; sampled on an accepted start.
- busy  output  1  high from an accepted start until done.
- done  output  1  one-cycle pulse when results are valid.
- rd_addr  input  $clog2(N)+1  readback index; carries the extra top bit.
- rdata  output  32  registered readback data.
- spin_out  output  N  decoded spins from the last completed window.

Behaviour:
- Reset values: busy=0, done=0, rdata=0, spin_out=0. All counters, synchronisers and FSM state also clear on reset.

Synchroniser:
- Each right_col bit passes through SYNC_STAGES flops.
- sync[i] denotes the last stage for bit i.

FSM: IDLE, CLEAR, MEASURE, DONE (one-hot or binary is an implementation choice).
- IDLE: start=1 → CLEAR. The cycles value is latched into win_len.
- CLEAR: one cycle. All counters and remaining are zeroed; remaining loads win_len.
  - remaining==0 → DONE.
  - Otherwise → MEASURE.
- MEASURE, each cycle:
  - For every i, if sync[i]==sync[N-1], count[i]++.
  - Counters saturate at all-ones; they do not wrap.
  - remaining decrements.
  - When the decrement takes remaining from 1 to 0 → DONE.
  - Exactly win_len samples are taken.
- DONE: one cycle.
  - done=1.
  - spin_out[i] is updated to (2·count[i] ≥ win_len), compared at COUNTER_WIDTH+1 bits.
  - → IDLE.
- Timing: start at cycle T gives done at T+2+win_len.
- busy=1 in CLEAR, MEASURE and DONE.
- start while busy is ignored and is not queued.
- start coincident with DONE is ignored.
- Counters hold their values in IDLE, so results stay readable until the next accepted start.
- Reset asserted mid-window aborts the window: FSM returns to IDLE, counters and spin_out clear, and no done pulse is produced.
- Reference bit: count[N-1] always equals win_len, so spin_out[N-1] is 1 after every non-empty window.
- Empty window (cycles=0): spin_out becomes all ones, since 0 ≥ 0.

Readback:
- rdata is registered with 1-cycle latency from rd_addr and updates every cycle in all states.
- rd_addr < N → count[rd_addr], zero-extended to 32 bits.
- Any other rd_addr → 32'hAAAAAAAA (except as noted under Optional Feature).

Optional Feature:
- Macro: PHASE_EDGE_COUNT_EN.
- Defined:
  - An extra COUNTER_WIDTH saturating counter counts rising edges of sync[N-1] during MEASURE.
  - Rising edge means the previous sample was 0 and the current sample is 1.
  - The counter clears in CLEAR and is read at rd_addr==N.
- Undefined:
  - No such counter exists.
  - rd_addr==N returns 32'hAAAAAAAA.

Decomposition:
- Shared package/defines header holds:
  - FSM state encodings.
  - RDATA_DEFAULT = 32'hAAAAAAAA, already the matrix's unmapped-read value.
  - The PHASE_EDGE_COUNT_EN macro.
- Natural sub-module: `phase_bit_counter`, instantiated N times in a generate loop.
  - Contains one synchroniser and one saturating counter.
  - Inputs: raw bit, synced ref, clr, en.
  - Outputs: synced bit, count.
  - Top level keeps the FSM, the window counter and the readback mux.

Test Plan:
- Reset: hold axi_rstn=0 with right_col toggling → busy=0, done=0, rdata=0, spin_out=0. After release, read rd_addr=0 → rdata=0.
- In-phase window: N=8, drive all bits from the same 10-cycle square wave, cycles=100, start → done at +102 cycles; every count=100; spin_out=8'hFF.
- Anti-phase window: bits 0–3 inverted relative to bit 7, cycles=100 → count[0..3] near 0 (within synchroniser skew of ±2); count[4..7] near 100; spin_out=8'hF0.
- Boundaries:
  - cycles=0 → done at +2, counts=0, spin_out=8'hFF.
  - start while busy → no restart; done timing unchanged.
  - COUNTER_WIDTH=4 with cycles=15 and constant input → counts=15, no wrap.
- Reset mid-window: assert axi_rstn at sample 40 of 100 → no done pulse; counts=0; a new start is accepted normally.
- Out-of-range readback: rd_addr=9 → 32'hAAAAAAAA.
- Optional feature, defined: reference at period 10 over 100 cycles → rd_addr=8 returns 10±1.
- Optional feature, undefined: rd_addr=8 returns 32'hAAAAAAAA.
